rf_port_scheduler: RTL

Sits between the reorder buffer and the register file and sequences that file's two write-type ports. It accepts up to two in-order commit writebacks per cycle into a small FIFO and drains them one per cycle onto the file's single writeback port. It gates the rename (dependency-tag) port, and turns a mispredict flush into a safe sequence: drain all committed writes first, then pulse the file's clear.

---
 rtl/rf_port_scheduler_pkg.sv | 24 ++
 rtl/rf_port_scheduler_wb_fifo.sv | 56 +++++
 rtl/rf_port_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/rf_port_scheduler_pkg.sv
// rf_port_scheduler_pkg
// Shared definitions for the register-file port scheduler:
//   ROB_W         - default RoB index width
//   sched_state_t - scheduler FSM states (RUN / DRAIN / CLEAR)
//   commit_rec_t  - packed commit writeback record {regid, value, robidx}
package rf_port_scheduler_pkg;

   localparam int unsigned ROB_W = 4;
   localparam int unsigned REG_W = 5;
   localparam int unsigned VAL_W = 32;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [REG_W-1:0] regid;
      logic [VAL_W-1:0] value;
      logic [ROB_W-1:0] robidx;
   } commit_rec_t;

endpackage

// File: rtl/rf_port_scheduler_wb_fifo.sv
// rf_wb_fifo
// Two-write / one-read circular FIFO of commit records.
// Ports:
//   clk_in, rst_n_in       - clock, asynchronous active-low reset
//   wr_a_en / wr_a_data    - first (older) write this cycle
//   wr_b_en / wr_b_data    - second write; only meaningful with wr_a_en
//   rd_en                  - pop the head (ignored when empty)
//   rd_data                - current head record
//   count / free           - occupancy and remaining space
module rf_wb_fifo
   import rf_port_scheduler_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          wr_a_en,
   input  commit_rec_t   wr_a_data,
   input  logic          wr_b_en,
   input  commit_rec_t   wr_b_data,
   input  logic          rd_en,
   output commit_rec_t   rd_data,
   output logic [CW-1:0] count,
   output logic [CW-1:0] free
);

   commit_rec_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [1:0]    n_wr;
   logic          rd_fire;

   assign n_wr    = {1'b0, wr_a_en} + {1'b0, wr_b_en};
   assign rd_fire = rd_en && (count != '0);
   assign rd_data = mem[rd_ptr];
   assign free    = CW'(DEPTH) - count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_a_en) mem[wr_ptr] <= wr_a_data;
         if (wr_b_en) mem[wr_ptr + AW'(1)] <= wr_b_data;
         wr_ptr <= wr_ptr + AW'(n_wr);
         if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(n_wr) - CW'(rd_fire);
      end
   end

endmodule

// File: rtl/rf_port_scheduler.sv
// rf_port_scheduler
// Sequences the register file's writeback and rename ports: buffers up to two
// in-order commits per cycle, drains one per cycle to the writeback port, gates
// rename, and turns a flush into drain-then-clear.
// Ports:
//   clk_in, rst_n_in, rdy_in          - clock, async active-low reset, enable
//   c0_* / c1_*, commit_ready         - commit slots (c0 older) and acceptance
//   flush_req, flush_done             - mispredict flush request / clear pulse
//   ren_*, ren_ready                  - rename request and acceptance
//   rf_index, rf_new_dep              - RF rename port (index 0 = none)
//   rf_cdb_regid/value/robidx         - registered RF writeback (regid 0 = none)
//   rf_clear                          - RF dependency clear
module rf_port_scheduler
   import rf_port_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ROB_W = rf_port_scheduler_pkg::ROB_W
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             rdy_in,
   input  logic             c0_valid,
   input  logic [4:0]       c0_regid,
   input  logic [31:0]      c0_value,
   input  logic [ROB_W-1:0] c0_robidx,
   input  logic             c1_valid,
   input  logic [4:0]       c1_regid,
   input  logic [31:0]      c1_value,
   input  logic [ROB_W-1:0] c1_robidx,
   output logic             commit_ready,
   input  logic             flush_req,
   output logic             flush_done,
   input  logic             ren_valid,
   input  logic [4:0]       ren_regid,
   input  logic [ROB_W-1:0] ren_robidx,
   output logic             ren_ready,
   output logic [4:0]       rf_index,
   output logic [ROB_W-1:0] rf_new_dep,
   output logic [4:0]       rf_cdb_regid,
   output logic [31:0]      rf_cdb_value,
   output logic [ROB_W-1:0] rf_cdb_robidx,
   output logic             rf_clear
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   sched_state_t  state;
   commit_rec_t   rec0, rec1, head;
   logic          keep0, keep1;
   logic          wr_a_en, wr_b_en, pop;
   logic [CW-1:0] fifo_count, fifo_free;

   assign rec0 = '{regid: c0_regid, value: c0_value, robidx: c0_robidx};
   assign rec1 = '{regid: c1_regid, value: c1_value, robidx: c1_robidx};

   // Register-0 slots are dropped; survivors are packed so the older one
   // always lands in the first write slot.
   assign keep0   = c0_valid && (c0_regid != '0);
   assign keep1   = c0_valid && c1_valid && (c1_regid != '0);
   assign wr_a_en = commit_ready && (keep0 || keep1);
   assign wr_b_en = commit_ready && keep0 && keep1;
   assign pop     = rdy_in && (fifo_count != '0);

   assign commit_ready = (state == ST_RUN) && (fifo_free >= CW'(2)) && rdy_in;
   assign ren_ready    = (state == ST_RUN) && rdy_in;
   assign rf_index     = (state == ST_RUN && ren_valid && rdy_in) ? ren_regid : '0;
   assign rf_new_dep   = ren_robidx;
   assign rf_clear     = (state == ST_CLEAR);
   assign flush_done   = (state == ST_CLEAR) && rdy_in;

   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .wr_a_en   (wr_a_en),
      .wr_a_data (keep0 ? rec0 : rec1),
      .wr_b_en   (wr_b_en),
      .wr_b_data (rec1),
      .rd_en     (pop),
      .rd_data   (head),
      .count     (fifo_count),
      .free      (fifo_free)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= ST_RUN;
         rf_cdb_regid  <= '0;
         rf_cdb_value  <= '0;
         rf_cdb_robidx <= '0;
      end else if (rdy_in) begin
         unique case (state)
            ST_RUN:   if (flush_req) state <= ST_DRAIN;
            // count==0 already implies no pop this cycle
            ST_DRAIN: if (fifo_count == '0) state <= ST_CLEAR;
            ST_CLEAR: state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
         if (pop) begin
            rf_cdb_regid  <= head.regid;
            rf_cdb_value  <= head.value;
            rf_cdb_robidx <= head.robidx;
         end else begin
            rf_cdb_regid  <= '0;
         end
      end
   end

endmodule
